// File: rtl/mem_ref_phase_sequencer.sv
// Phase sequencer for PDP-8 memory-reference execution: six two-slot phases (ckN level, stbN strobe).
// Optional single-step gating is compiled in with `define SEQ_SINGLE_STEP_EN.
module mem_ref_phase_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       start,
  input  logic       done,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  output logic       ck1,
  output logic       ck2,
  output logic       ck3,
  output logic       ck4,
  output logic       ck5,
  output logic       ck6,
  output logic       stb1,
  output logic       stb2,
  output logic       stb3,
  output logic       stb4,
  output logic       stb5,
  output logic       stb6,
  output logic       busy,
  output logic       seq_done,
  output logic       timeout,
  output logic [2:0] phase
);

  // Odd codes are the A slot of a phase, even non-zero codes the B slot.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_A1   = 4'd1,  S_B1 = 4'd2,
    S_A2   = 4'd3,  S_B2 = 4'd4,
    S_A3   = 4'd5,  S_B3 = 4'd6,
    S_A4   = 4'd7,  S_B4 = 4'd8,
    S_A5   = 4'd9,  S_B5 = 4'd10,
    S_A6   = 4'd11, S_B6 = 4'd12
  } state_e;

  state_e     state_q, state_d;
  logic       seq_done_q, seq_done_d;
  logic       timeout_q, timeout_d;
  logic       advance;
  logic [2:0] phase_w;
  logic [5:0] ck_vec;
  logic [5:0] stb_vec;

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = ~step_mode | step;
`else
  assign advance = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      seq_done_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_done_q <= seq_done_d;
      timeout_q  <= timeout_d;
    end
  end

  // NOTE: every signal gets a default at the top of the comb block, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    seq_done_d = 1'b0;
    timeout_d  = 1'b0;
    if (advance) begin
      if (state_q == S_IDLE) begin
        if (start && run) state_d = S_A1;
      end else if (done) begin
        state_d    = S_IDLE;
        seq_done_d = 1'b1;
      end else if (state_q == S_B6) begin
        state_d   = S_IDLE;
        timeout_d = 1'b1;
      end else begin
        state_d = state_e'(state_q + 4'd1);
      end
    end
  end

  // Phase number is ceil(code/2); strobe is the phase level gated by the B slot.
  always_comb begin
    phase_w = 3'((state_q + 4'd1) >> 1);
    ck_vec  = 6'b000000;
    if (phase_w != 3'd0) ck_vec = 6'b000001 << (phase_w - 3'd1);
    stb_vec = ((state_q != S_IDLE) && !state_q[0]) ? ck_vec : 6'b000000;
  end

  assign {ck6, ck5, ck4, ck3, ck2, ck1}       = ck_vec;
  assign {stb6, stb5, stb4, stb3, stb2, stb1} = stb_vec;
  assign busy     = (state_q != S_IDLE);
  assign phase    = phase_w;
  assign seq_done = seq_done_q;
  assign timeout  = timeout_q;

endmodule
